// File: rtl/ser_rd_pkg.sv
// Shared types and default sizing for the ser_rd_ctrl shift-register readback sequencer.
package ser_rd_pkg;

    localparam int unsigned SER_RD_LANES = 2;
    localparam int unsigned SER_RD_BITS  = 8;
    localparam int unsigned SER_RD_DIV   = 1;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        SETTLE   = 3'd2,
        SHIFT_LO = 3'd3,
        SHIFT_HI = 3'd4,
        DONE     = 3'd5
    } ser_rd_state_t;

endpackage

// File: rtl/ser_rd_phase_tick.sv
// DIV-cycle phase counter; phase_end marks the last cycle of each phase.
module ser_rd_phase_tick
    import ser_rd_pkg::*;
#(
    parameter int unsigned DIV = SER_RD_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic phase_end
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [PW-1:0] cnt;

    assign phase_end = (cnt == PW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (phase_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ser_rd_ctrl.sv
// Load/serial-clock sequencer for 74LS165-style shifters, reassembling lanes MSB-first.
// Optional SER_RD_CONT_EN adds a `cont` input for back-to-back word capture.
module ser_rd_ctrl
    import ser_rd_pkg::*;
#(
    parameter int unsigned LANES = SER_RD_LANES,
    parameter int unsigned BITS  = SER_RD_BITS,
    parameter int unsigned DIV   = SER_RD_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
`ifdef SER_RD_CONT_EN
    input  logic                  cont,
`endif
    input  logic [LANES-1:0]      ser_in,
    output logic                  busy,
    output logic                  shld_n,
    output logic                  serclk,
    output logic [LANES*BITS-1:0] data,
    output logic                  valid
);

    localparam int unsigned CW = (BITS > 1) ? $clog2(BITS) : 1;

    ser_rd_state_t         state;
    ser_rd_state_t         state_nx;
    logic [CW-1:0]         bit_cnt;
    logic [LANES*BITS-1:0] sreg;
    logic                  phase_end;
    logic                  last_bit;
    logic                  cont_en;

`ifdef SER_RD_CONT_EN
    assign cont_en = cont;
`else
    assign cont_en = 1'b0;
`endif

    assign last_bit = (bit_cnt == CW'(BITS - 1));

    ser_rd_phase_tick #(.DIV(DIV)) u_phase (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_nx != state),
        .phase_end (phase_end)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start)     state_nx = LOAD;
            LOAD:     if (phase_end) state_nx = SETTLE;
            SETTLE:   if (phase_end) state_nx = SHIFT_LO;
            SHIFT_LO: if (phase_end) state_nx = SHIFT_HI;
            SHIFT_HI: if (phase_end) state_nx = last_bit ? DONE : SHIFT_LO;
            DONE:     state_nx = cont_en ? LOAD : IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            shld_n  <= 1'b1;
            serclk  <= 1'b0;
            busy    <= 1'b0;
            valid   <= 1'b0;
            data    <= '0;
            sreg    <= '0;
            bit_cnt <= '0;
        end else begin
            state  <= state_nx;
            shld_n <= (state_nx != LOAD);
            serclk <= (state_nx == SHIFT_HI);
            busy   <= (state_nx != IDLE);
            valid  <= (state_nx == DONE);

            if (state == SETTLE) begin
                bit_cnt <= '0;
            end else if (state == SHIFT_HI && phase_end && !last_bit) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            // Sample on the same edge that raises serclk, so QH is read before it advances.
            if (state == SHIFT_LO && phase_end) begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    sreg[i*BITS +: BITS] <= {sreg[i*BITS +: BITS-1], ser_in[i]};
                end
            end

            if (state == SHIFT_HI && phase_end && last_bit) begin
                data <= sreg;
            end
        end
    end

endmodule
